// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480@60 raster constants and field layouts for the VGA scanner.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_timing_pkg;

    // Horizontal timing in pixel ticks
    localparam int H_VIS        = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;   // exclusive

    // Vertical timing in lines
    localparam int V_VIS        = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;   // exclusive

    localparam logic SYNC_ACTIVE = 1'b0;

    // RGB565 field positions
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [R_MSB-R_LSB:0] r;
        logic [G_MSB-G_LSB:0] g;
        logic [B_MSB-B_LSB:0] b;
    } rgb565_t;

    // Sync/visibility bundle carried alongside the colour lookup
    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, vis: 1'b0};

endpackage

// File: rtl/vga_scan_if.sv
// Purpose: bundle between the scanner, the colour lookup and the VGA connector.
// Latency: n/a (wires only).
// Backpressure: none; the raster never stalls.
interface vga_scan_if;
    logic [15:0] icolor;
    logic [9:0]  posX;
    logic [8:0]  posY;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        frame_start;

    // Scanner side
    modport master (
        input  icolor,
        output posX, posY, hs, vs, r, g, b, frame_start
    );

    // Lookup / connector side
    modport slave (
        output icolor,
        input  posX, posY, hs, vs, r, g, b, frame_start
    );
endinterface

// File: rtl/vga_delay_line.sv
// Purpose: DEPTH-stage shift register that advances only when en is high.
// Latency: DEPTH enabled cycles from d to q.
// Backpressure: none; en simply freezes all stages.
module vga_delay_line #(
    parameter int                WIDTH   = 3,
    parameter int                DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    // Shift one place toward the output on each enable
    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stage registers, cleared to the idle pattern on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= {DEPTH{RST_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan.sv
// Purpose: 640x480 raster scanner; presents coordinates, samples colour, drives sync/RGB.
// Latency: colour, sync and blank leave LAT pixel ticks after the coordinate is presented.
// Backpressure: none; free-running raster, icolor must be valid within CLK_DIV*LAT clk.
module vga_scan
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int LAT     = 1
) (
    input  logic     clk,
    input  logic     rst,
    vga_scan_if.master vga
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic [9:0]       posx_q, posx_d;
    logic [8:0]       posy_q, posy_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [3:0]       r_q, r_d;
    logic [3:0]       g_q, g_d;
    logic [3:0]       b_q, b_d;
    logic             frame_start_q, frame_start_d;
    sync_t            raw;
    sync_t            dly;
    rgb565_t          col;
    logic             unused_color_lsbs;

    assign tick = (div_q == DIV_LAST);
    assign col  = vga.icolor;

    // Only the top four bits of each colour field reach the DAC
    assign unused_color_lsbs = ^{col.r[0], col.g[1:0], col.b[0]};

    // Pixel divider, raster counters and coordinates; raw sync is derived from
    // the counter value being loaded so it enters the delay line with its coordinate
    always_comb begin
        div_d  = tick ? '0 : div_q + 1'b1;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (tick) begin
            if (hcnt_q == 10'(H_TOTAL - 1)) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == 10'(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
        raw.hs  = (hcnt_d >= 10'(H_SYNC_START) && hcnt_d < 10'(H_SYNC_END)) ?
                  SYNC_ACTIVE : ~SYNC_ACTIVE;
        raw.vs  = (vcnt_d >= 10'(V_SYNC_START) && vcnt_d < 10'(V_SYNC_END)) ?
                  SYNC_ACTIVE : ~SYNC_ACTIVE;
        raw.vis = (hcnt_d < 10'(H_VIS)) && (vcnt_d < 10'(V_VIS));
        posx_d  = (hcnt_d < 10'(H_VIS)) ? hcnt_d : '0;
        posy_d  = (vcnt_d < 10'(V_VIS)) ? vcnt_d[8:0] : '0;
        frame_start_d = tick && (hcnt_q == 10'(H_TOTAL - 1)) && (vcnt_q == 10'(V_TOTAL - 1));
    end

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (LAT),
        .RST_VAL (SYNC_IDLE)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .en  (tick),
        .d   (raw),
        .q   (dly)
    );

    // Output stage: sync and colour load together on tick; blanking forces black
    always_comb begin
        hs_d = hs_q;
        vs_d = vs_q;
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        if (tick) begin
            hs_d = dly.hs;
            vs_d = dly.vs;
            if (dly.vis) begin
                r_d = col.r[4:1];
                g_d = col.g[5:2];
                b_d = col.b[4:1];
            end else begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            posx_q        <= '0;
            posy_q        <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            posx_q        <= posx_d;
            posy_q        <= posy_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.posX        = posx_q;
    assign vga.posY        = posy_q;
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.r           = r_q;
    assign vga.g           = g_q;
    assign vga.b           = b_q;
    assign vga.frame_start = frame_start_q;

endmodule
